// File: rtl/inst_fifo_pkg.sv
// Shared types and defaults for the dual-issue instruction buffer.
// Define INST_FIFO_ADEL_EN to store a per-entry fetch address-error (adel) flag.
package inst_fifo_pkg;

   localparam int INST_FIFO_DEPTH = 16;

   typedef struct packed {
`ifdef INST_FIFO_ADEL_EN
      logic        adel;
`endif
      logic [31:0] inst;
      logic [31:0] pc;
   } inst_entry_t;

`ifdef INST_FIFO_ADEL_EN
   // A fetch address is misaligned whenever either of the two low PC bits is set.
   function automatic logic pc_misaligned(input logic [31:0] pc);
      return |pc[1:0];
   endfunction
`endif

endpackage

// File: rtl/inst_fifo_ram.sv
// Entry storage for inst_fifo: two write ports and two combinational read ports.
// Port 1 (index 1) wins when both write ports hit the same index.
module inst_fifo_ram
   import inst_fifo_pkg::*;
#(
   parameter int DEPTH = INST_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic [1:0]             we,
   input  logic [1:0][AW-1:0]     waddr,
   input  inst_entry_t [1:0]      wdata,
   input  logic [1:0][AW-1:0]     raddr,
   output inst_entry_t [1:0]      rdata
);

   inst_entry_t mem [DEPTH];

   // Later loop iteration overrides the earlier one on an address collision.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (we[i]) begin
            mem[waddr[i]] <= wdata[i];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         assign rdata[gi] = mem[raddr[gi]];
      end
   endgenerate

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction buffer between fetch and the two decode slots.
// Optional INST_FIFO_ADEL_EN adds out_adel1/out_adel2 misaligned-fetch flags.
module inst_fifo
   import inst_fifo_pkg::*;
#(
   parameter int DEPTH = INST_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_en1,
   input  logic        in_en2,
   input  logic [31:0] in_inst1,
   input  logic [31:0] in_inst2,
   input  logic [31:0] in_pc1,
   input  logic [31:0] in_pc2,
   output logic        full,
   output logic        empty,
   input  logic        pop1,
   input  logic        pop2,
   input  logic        stall,
   output logic        out_valid1,
   output logic        out_valid2,
   output logic [31:0] out_inst1,
   output logic [31:0] out_inst2,
   output logic [31:0] out_pc1,
`ifdef INST_FIFO_ADEL_EN
   output logic        out_adel1,
   output logic        out_adel2,
`endif
   output logic [31:0] out_pc2
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;

   logic [1:0] push_num;
   logic [1:0] pop_num;

   logic [1:0]          ram_we;
   logic [1:0][AW-1:0]  ram_waddr;
   inst_entry_t [1:0]   ram_wdata;
   logic [1:0][AW-1:0]  ram_raddr;
   inst_entry_t [1:0]   ram_rdata;

   // Flags come straight from the registered count.
   assign full       = count_reg > CW'(DEPTH - 2);
   assign empty      = count_reg == '0;
   assign out_valid1 = count_reg >= CW'(1);
   assign out_valid2 = count_reg >= CW'(2);

   always_comb begin
      push_num = 2'd0;
      if (!full && in_en1) begin
         push_num = in_en2 ? 2'd2 : 2'd1;
      end
   end

   always_comb begin
      pop_num = 2'd0;
      if (!stall) begin
         pop_num = {1'b0, pop1 & out_valid1} + {1'b0, pop1 & pop2 & out_valid2};
      end
   end

   always_comb begin
      wr_ptr_next = wr_ptr_reg + AW'(push_num);
      rd_ptr_next = rd_ptr_reg + AW'(pop_num);
      count_next  = count_reg + CW'(push_num) - CW'(pop_num);
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Writes in a flush cycle land in storage but are never made visible.
   assign ram_we[0]    = push_num != 2'd0;
   assign ram_we[1]    = push_num == 2'd2;
   assign ram_waddr[0] = wr_ptr_reg;
   assign ram_waddr[1] = wr_ptr_reg + AW'(1);
   assign ram_raddr[0] = rd_ptr_reg;
   assign ram_raddr[1] = rd_ptr_reg + AW'(1);

   always_comb begin
      ram_wdata         = '0;
      ram_wdata[0].inst = in_inst1;
      ram_wdata[0].pc   = in_pc1;
      ram_wdata[1].inst = in_inst2;
      ram_wdata[1].pc   = in_pc2;
`ifdef INST_FIFO_ADEL_EN
      ram_wdata[0].adel = pc_misaligned(in_pc1);
      ram_wdata[1].adel = pc_misaligned(in_pc2);
`endif
   end

   inst_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Invalid slots present a NOP at PC 0 so decode never sees stale entries.
   assign out_inst1 = out_valid1 ? ram_rdata[0].inst : 32'h0;
   assign out_pc1   = out_valid1 ? ram_rdata[0].pc   : 32'h0;
   assign out_inst2 = out_valid2 ? ram_rdata[1].inst : 32'h0;
   assign out_pc2   = out_valid2 ? ram_rdata[1].pc   : 32'h0;
`ifdef INST_FIFO_ADEL_EN
   assign out_adel1 = out_valid1 ? ram_rdata[0].adel : 1'b0;
   assign out_adel2 = out_valid2 ? ram_rdata[1].adel : 1'b0;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo: a queue-based reference model predicts the
// slot outputs after every edge; a separate monitor compares them.
module tb_inst_fifo;

   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   typedef struct {
      logic        valid1, valid2, full, empty, adel1, adel2;
      logic [31:0] inst1, pc1, inst2, pc2;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1, flush = 1'b0;
   logic        in_en1 = 1'b0, in_en2 = 1'b0;
   logic [31:0] in_inst1 = '0, in_inst2 = '0, in_pc1 = '0, in_pc2 = '0;
   logic        pop1 = 1'b0, pop2 = 1'b0, stall = 1'b0;
   logic        full, empty, out_valid1, out_valid2;
   logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
`ifdef INST_FIFO_ADEL_EN
   logic        out_adel1, out_adel2;
`endif

   ent_t  model_q[$];
   snap_t exp_q[$];
   int    n_checks = 0;
   int    n_err    = 0;
   int    cyc      = 0;
   logic [31:0] seq_pc = 32'hBFC00000;

   always #5 clk = ~clk;

   inst_fifo #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_en1     (in_en1),
      .in_en2     (in_en2),
      .in_inst1   (in_inst1),
      .in_inst2   (in_inst2),
      .in_pc1     (in_pc1),
      .in_pc2     (in_pc2),
      .full       (full),
      .empty      (empty),
      .pop1       (pop1),
      .pop2       (pop2),
      .stall      (stall),
      .out_valid1 (out_valid1),
      .out_valid2 (out_valid2),
      .out_inst1  (out_inst1),
      .out_inst2  (out_inst2),
      .out_pc1    (out_pc1),
`ifdef INST_FIFO_ADEL_EN
      .out_adel1  (out_adel1),
      .out_adel2  (out_adel2),
`endif
      .out_pc2    (out_pc2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge and record what must be visible after the next rise.
   task automatic drive(input logic r, input logic f, input logic e1, input logic e2,
                        input logic p1, input logic p2, input logic st,
                        input logic [31:0] i1, input logic [31:0] a1,
                        input logic [31:0] i2, input logic [31:0] a2);
      int    m;
      int    npush;
      int    npop;
      int    sz;
      snap_t s;
      @(negedge clk);
      rst = r; flush = f; in_en1 = e1; in_en2 = e2; pop1 = p1; pop2 = p2; stall = st;
      in_inst1 = i1; in_pc1 = a1; in_inst2 = i2; in_pc2 = a2;
      m     = model_q.size();
      npush = (m > DEPTH - 2 || !e1) ? 0 : (e2 ? 2 : 1);
      npop  = st ? 0 : (((p1 && m >= 1) ? 1 : 0) + ((p1 && p2 && m >= 2) ? 1 : 0));
      if (r || f) begin
         model_q.delete();
      end else begin
         repeat (npop) void'(model_q.pop_front());
         if (npush >= 1) model_q.push_back('{inst: i1, pc: a1});
         if (npush == 2) model_q.push_back('{inst: i2, pc: a2});
      end
      sz       = model_q.size();
      s.valid1 = sz >= 1;
      s.valid2 = sz >= 2;
      s.full   = sz > DEPTH - 2;
      s.empty  = sz == 0;
      s.inst1  = (sz >= 1) ? model_q[0].inst : 32'h0;
      s.pc1    = (sz >= 1) ? model_q[0].pc   : 32'h0;
      s.inst2  = (sz >= 2) ? model_q[1].inst : 32'h0;
      s.pc2    = (sz >= 2) ? model_q[1].pc   : 32'h0;
      s.adel1  = (sz >= 1) && (model_q[0].pc[1:0] != 2'b00);
      s.adel2  = (sz >= 2) && (model_q[1].pc[1:0] != 2'b00);
      exp_q.push_back(s);
   endtask

   // Sequential instruction stream with aligned PCs for directed phases.
   task automatic step(input logic e1, input logic e2, input logic p1, input logic p2);
      drive(1'b0, 1'b0, e1, e2, p1, p2, 1'b0,
            32'h24000000 | seq_pc[15:0], seq_pc, 32'h24100000 | seq_pc[15:0], seq_pc + 32'd4);
      seq_pc = seq_pc + 32'd8;
   endtask

   task automatic flush_cycle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   // Monitor: compares DUT outputs against the oldest pending expectation.
   initial begin
      snap_t s;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            $display("cyc %0d v=%b%b full=%b empty=%b s0=%h@%h s1=%h@%h", cyc, out_valid1,
                     out_valid2, full, empty, out_inst1, out_pc1, out_inst2, out_pc2);
            chk("valid1", {31'b0, out_valid1}, {31'b0, s.valid1});
            chk("valid2", {31'b0, out_valid2}, {31'b0, s.valid2});
            chk("full",   {31'b0, full},       {31'b0, s.full});
            chk("empty",  {31'b0, empty},      {31'b0, s.empty});
            chk("inst1",  out_inst1, s.inst1);
            chk("pc1",    out_pc1,   s.pc1);
            chk("inst2",  out_inst2, s.inst2);
            chk("pc2",    out_pc2,   s.pc2);
`ifdef INST_FIFO_ADEL_EN
            chk("adel1",  {31'b0, out_adel1}, {31'b0, s.adel1});
            chk("adel2",  {31'b0, out_adel2}, {31'b0, s.adel2});
`endif
         end
      end
   end

   initial begin
      logic e1, e2, p1, p2, st, fl, rs;
      logic [31:0] a1;
      // Reset, then the first pair becomes visible one cycle after the push.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h4, 32'h2, 32'h8);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
            32'h24080001, 32'hBFC00000, 32'h24090002, 32'hBFC00004);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Third entry, then a single-issue pop.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Paired fill from empty: full at 16, pushes while full are rejected.
      flush_cycle();
      repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0);
      // Odd fill to 15, push+pop at 15, then push 2 / pop 2 at 14.
      flush_cycle();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Wrap: wr_ptr to 15, drain to one entry, push across the end, drain in order.
      flush_cycle();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
      // Flush with 8 entries while pushing 2 and popping 2.
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h20, 32'h22, 32'h24);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Stalled pops, then pop2 with a single entry.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '0, '0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      // Misaligned fetch PC.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
            32'h24080003, 32'hBFC00002, 32'h24080004, 32'hBFC00008);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Mid-stream reset then a fresh push.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         e1 = ($urandom_range(99) < 70);
         e2 = ($urandom_range(99) < 60);
         p1 = ($urandom_range(99) < 60);
         p2 = ($urandom_range(99) < 60);
         st = ($urandom_range(99) < 15);
         fl = ($urandom_range(99) < 2);
         rs = ($urandom_range(199) < 1);
         a1 = $urandom;
         if ($urandom_range(3) != 0) a1[1:0] = 2'b00;
         drive(rs, fl, e1, e2, p1, p2, st, $urandom, a1, $urandom, a1 + 32'd4);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
